imm_packer: RTL and testbench

- Inverse of the datapath sign-extend stage: takes a signed 64-bit immediate plus a 32-bit base instruction and packs the immediate into the correct LEGv8 field.
- Supported formats: D (LDUR/STUR), CB (CBZ), I (ADDI/SUBI).
- Range-checks the immediate, assigns each packed word a sequential instruction-memory byte address, and buffers results in a small FIFO.
- Sits in the program-load path feeding instruction memory.

---
 rtl/imm_packer.sv | 140 ++++++++++++++
 tb/tb_imm_packer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/imm_packer.sv
// rtl/imm_packer.sv - packs signed immediates into LEGv8 D/CB/I fields and queues addressed words
// Optional macro IMM_SATURATE_EN: clamp out-of-range immediates instead of dropping them.
module imm_packer #(
  parameter int                 ADDR_W    = 64,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = '0,
  parameter int                 DEPTH     = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_kind,
  input  logic [31:0]       in_base,
  input  logic [63:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err_pulse,
  output logic [7:0]        err_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] KIND_D  = 2'b00;
  localparam logic [1:0] KIND_CB = 2'b01;
  localparam logic [1:0] KIND_I  = 2'b10;

`ifdef IMM_SATURATE_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  logic [31:0]       mem_instr [DEPTH];
  logic [ADDR_W-1:0] mem_addr  [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     rd_nxt;
  logic [CW-1:0]     count;
  logic [ADDR_W-1:0] addr_cnt;

  logic              in_range;
  logic [8:0]        f_d;
  logic [18:0]       f_cb;
  logic [11:0]       f_i;
  logic [31:0]       packed_word;
  logic              acc;
  logic              push;
  logic              pop;

  // Field value is either the raw low bits or, when clamping, the signed extreme of the field.
  always_comb begin
    in_range    = 1'b1;
    f_d         = in_imm[8:0];
    f_cb        = in_imm[18:0];
    f_i         = in_imm[11:0];
    packed_word = in_base;
    case (in_kind)
      KIND_D: begin
        in_range = (&in_imm[63:8]) | ~(|in_imm[63:8]);
        if (SAT_EN && !in_range) f_d = {in_imm[63], {8{~in_imm[63]}}};
        packed_word = {in_base[31:21], f_d, in_base[11:0]};
      end
      KIND_CB: begin
        in_range = (&in_imm[63:18]) | ~(|in_imm[63:18]);
        if (SAT_EN && !in_range) f_cb = {in_imm[63], {18{~in_imm[63]}}};
        packed_word = {in_base[31:24], f_cb, in_base[4:0]};
      end
      KIND_I: begin
        in_range = (&in_imm[63:11]) | ~(|in_imm[63:11]);
        if (SAT_EN && !in_range) f_i = {in_imm[63], {11{~in_imm[63]}}};
        packed_word = {in_base[31:22], f_i, in_base[9:0]};
      end
      default: begin
        in_range    = 1'b1;
        packed_word = in_base;
      end
    endcase
  end

  assign in_ready  = (count < CW'(DEPTH));
  assign out_valid = (count != '0);
  assign acc       = in_valid && in_ready;
  assign push      = acc && (in_range || SAT_EN);
  assign pop       = out_valid && out_ready;
  assign rd_nxt    = rd_ptr + PW'(1);

  // Storage carries no reset; only entries between the pointers are ever observed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_instr[wr_ptr] <= packed_word;
      mem_addr[wr_ptr]  <= addr_cnt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      addr_cnt  <= BASE_ADDR;
      out_instr <= '0;
      out_addr  <= '0;
      err_pulse <= 1'b0;
      err_count <= '0;
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + PW'(1);
        addr_cnt <= addr_cnt + ADDR_W'(4);
      end
      if (pop) rd_ptr <= rd_nxt;

      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      // Head registers: refill from the next entry on pop, or from the input when it lands in an empty slot.
      if (pop) begin
        if (count > CW'(1)) begin
          out_instr <= mem_instr[rd_nxt];
          out_addr  <= mem_addr[rd_nxt];
        end else if (push) begin
          out_instr <= packed_word;
          out_addr  <= addr_cnt;
        end
      end else if (push && count == '0) begin
        out_instr <= packed_word;
        out_addr  <= addr_cnt;
      end

      err_pulse <= acc && !in_range;
      if (acc && !in_range && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_imm_packer.sv
// tb/tb_imm_packer.sv - directed self-checking bench for imm_packer
module tb_imm_packer;

`ifdef IMM_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, err_pulse;
  logic [1:0]  in_kind;
  logic [31:0] in_base, out_instr;
  logic [63:0] in_imm, out_addr;
  logic [7:0]  err_count;

  logic        s_rst_n;
  logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_err_pulse;
  logic [1:0]  s_in_kind;
  logic [31:0] s_in_base, s_out_instr;
  logic [63:0] s_in_imm;
  logic [3:0]  s_out_addr;
  logic [7:0]  s_err_count;

  int total = 0;
  int bad   = 0;
  logic [63:0] a;

  always #5 clk = ~clk;

  imm_packer dut (
    .clk(clk), .reset(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
    .in_base(in_base), .in_imm(in_imm), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr), .err_pulse(err_pulse), .err_count(err_count)
  );

  imm_packer #(.ADDR_W(4), .BASE_ADDR(4'd8), .DEPTH(2)) dut_s (
    .clk(clk), .reset(s_rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_kind(s_in_kind),
    .in_base(s_in_base), .in_imm(s_in_imm), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_instr(s_out_instr), .out_addr(s_out_addr), .err_pulse(s_err_pulse), .err_count(s_err_count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] k, input logic [31:0] b, input logic [63:0] imm);
    in_valid = 1'b1; in_kind = k; in_base = b; in_imm = imm;
  endtask

  task automatic sdrive(input logic [1:0] k, input logic [31:0] b, input logic [63:0] imm);
    s_in_valid = 1'b1; s_in_kind = k; s_in_base = b; s_in_imm = imm;
  endtask

  initial begin
    rst_n = 1'b0; s_rst_n = 1'b0;
    in_valid = 1'b0; in_kind = 2'b00; in_base = '0; in_imm = '0; out_ready = 1'b0;
    s_in_valid = 1'b0; s_in_kind = 2'b00; s_in_base = '0; s_in_imm = '0; s_out_ready = 1'b1;
    step(); step();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_instr", 64'(out_instr), 64'd0);
    check("rst_out_addr", out_addr, 64'd0);
    check("rst_err_pulse", 64'(err_pulse), 64'd0);
    check("rst_err_count", 64'(err_count), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    #2; rst_n = 1'b1; s_rst_n = 1'b1;

    // D, imm -1
    drive(2'b00, 32'hF840_0000, -64'sd1);
    step(); in_valid = 1'b0;
    check("d_valid", 64'(out_valid), 64'd1);
    check("d_instr", 64'(out_instr), 64'hF85F_F000);
    check("d_addr", out_addr, 64'd0);
    check("d_err", 64'(err_pulse), 64'd0);
    out_ready = 1'b1;
    step();
    check("d_pop_empty", 64'(out_valid), 64'd0);
    check("d_hold_instr", 64'(out_instr), 64'hF85F_F000);
    a = 64'd4;

    // CB -2 then I 100, held back until both are queued
    out_ready = 1'b0;
    drive(2'b01, 32'hB400_0000, -64'sd2);
    step();
    drive(2'b10, 32'h9100_0000, 64'd100);
    step(); in_valid = 1'b0;
    check("cb_full", 64'(in_ready), 64'd0);
    check("cb_instr", 64'(out_instr), 64'hB4FF_FFC0);
    check("cb_addr", out_addr, a);
    out_ready = 1'b1;
    step();
    check("i_instr", 64'(out_instr), 64'h9101_9000);
    check("i_addr", out_addr, a + 64'd4);
    step();
    check("ci_empty", 64'(out_valid), 64'd0);
    a = a + 64'd8;

    // D 256 is out of range
    drive(2'b00, 32'hF840_0000, 64'd256);
    step(); in_valid = 1'b0;
    check("oor_pulse", 64'(err_pulse), 64'd1);
    check("oor_count", 64'(err_count), 64'd1);
    check("oor_valid", 64'(out_valid), 64'(SAT));
    check("oor_instr", 64'(out_instr), SAT ? 64'hF84F_F000 : 64'h9101_9000);
    check("oor_addr", out_addr, SAT ? a : a - 64'd4);
    step();
    check("oor_pulse_drop", 64'(err_pulse), 64'd0);
    check("oor_count_hold", 64'(err_count), 64'd1);
    a = a + (SAT ? 64'd4 : 64'd0);

    // field boundaries
    drive(2'b00, 32'hF840_0000, -64'sd256);
    step();
    check("dmin_instr", 64'(out_instr), 64'hF850_0000);
    check("dmin_addr", out_addr, a);
    drive(2'b10, 32'h9100_0000, -64'sd2048);
    step();
    check("imin_instr", 64'(out_instr), 64'h9120_0000);
    check("imin_addr", out_addr, a + 64'd4);
    check("imin_err", 64'(err_count), 64'd1);
    drive(2'b01, 32'hB400_0000, 64'd262144);
    step(); in_valid = 1'b0;
    check("cbmax_pulse", 64'(err_pulse), 64'd1);
    check("cbmax_count", 64'(err_count), 64'd2);
    check("cbmax_valid", 64'(out_valid), 64'(SAT));
    check("cbmax_instr", 64'(out_instr), SAT ? 64'hB47F_FFE0 : 64'h9120_0000);
    step();
    a = a + 64'd8 + (SAT ? 64'd4 : 64'd0);

    // backpressure with three words
    out_ready = 1'b0;
    drive(2'b10, 32'h9100_0000, 64'd1);
    step();
    check("bp_ready1", 64'(in_ready), 64'd1);
    drive(2'b10, 32'h9100_0000, 64'd2);
    step();
    check("bp_ready2", 64'(in_ready), 64'd0);
    check("bp_head", 64'(out_instr), 64'h9100_0400);
    drive(2'b10, 32'h9100_0000, 64'd3);
    step();
    check("bp_head_stable", 64'(out_instr), 64'h9100_0400);
    check("bp_addr_stable", out_addr, a);
    out_ready = 1'b1;
    step();
    check("bp_w1", 64'(out_instr), 64'h9100_0800);
    check("bp_w1_addr", out_addr, a + 64'd4);
    check("bp_ready3", 64'(in_ready), 64'd1);
    step(); in_valid = 1'b0;
    check("bp_w2", 64'(out_instr), 64'h9100_0C00);
    check("bp_w2_addr", out_addr, a + 64'd8);
    step();
    check("bp_empty", 64'(out_valid), 64'd0);
    a = a + 64'd12;

    // steady push+pop with one entry resident
    out_ready = 1'b0;
    drive(2'b10, 32'h9100_0000, 64'h10);
    step();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(2'b10, 32'h9100_0000, 64'(i + 32));
      step();
      check("pp_valid", 64'(out_valid), 64'd1);
      check("pp_ready", 64'(in_ready), 64'd1);
      check("pp_instr", 64'(out_instr), 64'h9100_0000 | (64'(i + 32) << 10));
      check("pp_addr", out_addr, a + 64'(4 * (i + 1)));
    end
    in_valid = 1'b0;
    step();
    check("pp_drain", 64'(out_valid), 64'd0);

    // narrow address counter wraps
    sdrive(2'b11, 32'hDEAD_BEEF, 64'd0);
    step();
    check("s_raw_instr", 64'(s_out_instr), 64'hDEAD_BEEF);
    check("s_addr8", 64'(s_out_addr), 64'd8);
    sdrive(2'b11, 32'h1234_5678, 64'd0);
    step();
    check("s_addr12", 64'(s_out_addr), 64'd12);
    sdrive(2'b11, 32'h0BAD_F00D, 64'd0);
    step();
    check("s_addr0", 64'(s_out_addr), 64'd0);
    check("s_wrap_instr", 64'(s_out_instr), 64'h0BAD_F00D);
    s_in_valid = 1'b0;
    step();

    // fill, then reset asynchronously mid-cycle
    s_out_ready = 1'b0;
    sdrive(2'b00, 32'hF840_0000, 64'd256);
    step();
    sdrive(2'b11, 32'h0000_0001, 64'd0);
    step();
    sdrive(2'b11, 32'h0000_0002, 64'd0);
    step(); s_in_valid = 1'b0;
    check("s_full", 64'(s_in_ready), 64'd0);
    check("s_full_valid", 64'(s_out_valid), 64'd1);
    check("s_err1", 64'(s_err_count), 64'd1);
    #2; s_rst_n = 1'b0;
    #1;
    check("s_rst_valid", 64'(s_out_valid), 64'd0);
    check("s_rst_err", 64'(s_err_count), 64'd0);
    check("s_rst_ready", 64'(s_in_ready), 64'd1);
    #2; s_rst_n = 1'b1;
    sdrive(2'b11, 32'hCAFE_0001, 64'd0);
    step(); s_in_valid = 1'b0;
    check("s_post_rst_addr", 64'(s_out_addr), 64'd8);
    check("s_post_rst_instr", 64'(s_out_instr), 64'hCAFE_0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
